// File: rtl/rs485_rx_pkg.sv
// Shared definitions for the RS485 receive path.
//   - APB register offsets
//   - CTRL and STATUS bit positions
//   - receiver FSM state encoding
package rs485_rx_pkg;

  localparam logic [7:0] AddrRxData = 8'h00;
  localparam logic [7:0] AddrCount  = 8'h04;
  localparam logic [7:0] AddrCtrl   = 8'h08;
  localparam logic [7:0] AddrStatus = 8'h0C;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlFlushBit = 1;

  localparam int unsigned StatEmptyBit    = 0;
  localparam int unsigned StatFullBit     = 1;
  localparam int unsigned StatOverrunBit  = 2;
  localparam int unsigned StatFrameErrBit = 3;
  localparam int unsigned StatBusyBit     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

endpackage

// File: rtl/rs485_rx_fifo.sv
// Byte FIFO for the RS485 receive path.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/wdata_i: write a byte (ignored when full unless popping in the same cycle)
//   pop_i         : drop the head (ignored when empty); rdata_o always shows the head
//   flush_i       : empty the FIFO; overrides push and pop
//   count_o, full_o, empty_o: registered occupancy and its decodes
module rs485_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [7:0]   wdata_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [7:0]   rdata_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO may still accept a push.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rs485_apb_receiver.sv
// RS485 receive path with APB register access.
//   PCLK, PRESETN           : clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY : APB slave, zero wait states
//   Rx                      : asynchronous serial line, 8N1, idle high
//   Rx_Enable               : transceiver receive enable (CTRL.en)
//   rx_irq                  : level interrupt while enabled and data is waiting
module rs485_apb_receiver
  import rs485_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned DEPTH    = 16
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [15:0] PWDATA,
  output logic [15:0] PRDATA,
  output logic        PREADY,
  input  logic        Rx,
  output logic        Rx_Enable,
  output logic        rx_irq
);

  localparam int unsigned TW = $clog2(BAUD_DIV + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [TW-1:0] HalfBit = TW'(BAUD_DIV / 2);
  localparam logic [TW-1:0] FullBit = TW'(BAUD_DIV);

  rx_state_e     state_q, state_d;
  logic          rx_meta_q, rx_meta_d, rxs_q, rxs_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          en_q, en_d;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;

  logic          access, rd_acc, wr_acc, ctrl_wr, stat_wr;
  logic          pop, flush, fall, tick, byte_ok, frame_set, overrun_set, busy;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic [15:0]   status_word;
  logic          unused_pwdata;

  assign unused_pwdata = ^PWDATA[15:4];

  assign access  = PSEL & PENABLE;
  assign rd_acc  = access & ~PWRITE;
  assign wr_acc  = access & PWRITE;
  assign ctrl_wr = wr_acc & (PADDR == AddrCtrl);
  assign stat_wr = wr_acc & (PADDR == AddrStatus);
  assign pop     = rd_acc & (PADDR == AddrRxData) & ~empty;
  assign flush   = ctrl_wr & PWDATA[CtrlFlushBit];

  // rxs_d is the value rxs takes at the next edge, so the state enters START
  // on the very edge where rxs first shows 0.
  assign fall = rxs_q & ~rx_meta_q;
  assign tick = (timer_q == TW'(1));
  assign busy = (state_q != StIdle);

  // A stopped frame with a full FIFO is only an overrun if no pop makes room
  // and no flush discards it anyway.
  assign overrun_set = byte_ok & full & ~pop & ~flush;

  always_comb begin
    rx_meta_d   = Rx;
    rxs_d       = rx_meta_q;
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_ok     = 1'b0;
    frame_set   = 1'b0;
    if (!en_q) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fall) begin
            state_d = StStart;
            timer_d = HalfBit;
          end
        end
        StStart: begin
          timer_d = timer_q - 1'b1;
          if (tick) begin
            if (!rxs_q) begin
              state_d   = StData;
              timer_d   = FullBit;
              bit_idx_d = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StData: begin
          timer_d = timer_q - 1'b1;
          if (tick) begin
            shift_d = {rxs_q, shift_q[7:1]};
            timer_d = FullBit;
            if (bit_idx_q == 3'd7) state_d = StStop;
            else                   bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        StStop: begin
          timer_d = timer_q - 1'b1;
          if (tick) begin
            if (rxs_q) begin
              byte_ok = 1'b1;
              state_d = StIdle;
            end else begin
              frame_set = 1'b1;
              state_d   = StWaitIdle;
            end
          end
        end
        StWaitIdle: begin
          if (rxs_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Register updates; sticky set wins over a same-cycle write-1-to-clear.
  always_comb begin
    en_d        = ctrl_wr ? PWDATA[CtrlEnBit] : en_q;
    overrun_d   = overrun_set |
                  (overrun_q & ~(stat_wr & PWDATA[StatOverrunBit]));
    frame_err_d = frame_set |
                  (frame_err_q & ~(stat_wr & PWDATA[StatFrameErrBit]));
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= StIdle;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      en_q        <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      en_q        <= en_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  rs485_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETN),
    .push_i  (byte_ok),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    status_word                  = '0;
    status_word[StatEmptyBit]    = empty;
    status_word[StatFullBit]     = full;
    status_word[StatOverrunBit]  = overrun_q;
    status_word[StatFrameErrBit] = frame_err_q;
    status_word[StatBusyBit]     = busy;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_acc) begin
      unique case (PADDR)
        AddrRxData: PRDATA = empty ? 16'h0000 : {8'h00, head};
        AddrCount:  PRDATA = 16'(count);
        AddrCtrl:   PRDATA = {15'b0, en_q};
        AddrStatus: PRDATA = status_word;
        default:    PRDATA = '0;
      endcase
    end
  end

  assign PREADY    = 1'b1;
  assign Rx_Enable = en_q;
  assign rx_irq    = en_q & ~empty;

endmodule
